hms_clock_counter: RTL
======================

// Module: hms_clock_counter
//
// PURPOSE
// Parametrised hours/minutes/seconds clock/timer core.
// - Internal prescaler turns the system clock into 1 s steps.
// - Counts up (wall clock / stopwatch) or down (countdown with done flag).
// - Supports pause, synchronous preset and a BCD-packed display word.
// - Sits between the board clock and the 7-segment display driver.
//
// PARAMETERS
// TICK_DIV   100_000_000      clk cycles per 1 s step; must be >= 2
// TICK_W     $clog2(TICK_DIV) prescaler width (derived)
// HOUR_MAX   23               last hour value before wrap; range 1..99
//
// PORTS
// clk      in   1   system clock, all logic on posedge
// rst      in   1   asynchronous, active-high reset
// run      in   1   1 = prescaler advances, 0 = pause (holds partial count)
// dir      in   1   1 = count up, 0 = count down
// load     in   1   1-cycle preset strobe
// load_h   in   8   preset hours (binary)
// load_m   in   8   preset minutes (binary)
// load_s   in   8   preset seconds (binary)
// hours    out  8   current hours, binary
// minutes  out  8   current minutes, binary
// seconds  out  8   current seconds, binary
// number   out  24  BCD {h_tens,h_ones,m_tens,m_ones,s_tens,s_ones}, 4 bits each
// tick     out  1   1-cycle pulse on every applied 1 s step
// wrap     out  1   1-cycle pulse on up-count wrap HOUR_MAX:59:59 -> 00:00:00
// done     out  1   sticky; set when down-count reaches 00:00:00
//
// BEHAVIOUR
// - Reset (async assert, sync release): h/m/s=0, prescaler=0, tick=wrap=done=0, number=0.
// - Prescaler:
//   - Increments each cycle while run=1 && !(dir=0 && done).
//   - At TICK_DIV-1 it returns to 0 and a step is applied on that same edge.
//   - Counter registers, tick and wrap update together in that cycle.
//   - Step latency is exactly TICK_DIV run-cycles.
// - Up step:
//   - s+1; at s=59, s=0 with carry to m.
//   - At m=59, m=0 with carry to h.
//   - At h=HOUR_MAX, h=0 and wrap=1.
// - Down step:
//   - s-1; at s=0, s=59 with borrow from m.
//   - At m=0, m=59 with borrow from h.
//   - A step that lands on 00:00:00 sets done.
//   - While done=1 and dir=0: prescaler frozen, no steps, no tick.
// - done:
//   - Cleared by load, by rst, or by dir=1 (up-count resumes on the next step).
//   - Never set in up mode.
// - load:
//   - Priority over any step in the same cycle; that step is discarded.
//   - Registers take clamped values: s=min(load_s,59), m=min(load_m,59), h=min(load_h,HOUR_MAX).
//   - Prescaler=0, done=0, tick=wrap=0 in that cycle.
//   - Loading 00:00:00 with dir=0 leaves done=0; the first down step then borrows to HOUR_MAX:59:59.
// - dir change mid-second: the prescaler is not reset; the next step uses the new direction.
// - run=0: all outputs hold and tick/wrap stay 0; the partial prescaler count is preserved.
// - number: combinational binary->BCD of the registered h/m/s (each value <= 99).
// - tick and wrap are registered single-cycle pulses, never asserted two cycles in a row (TICK_DIV >= 2).
// - Reset asserted mid-count: all state returns to reset values immediately.
//
// TESTING (TICK_DIV=4, HOUR_MAX=23)
// 1. rst then run=1, dir=1 for 12 cycles
//    -> seconds 1,2,3 on cycles 4,8,12; tick pulses each time; number=24'h000003.
// 2. load 23:59:58, dir=1, run 8 cycles
//    -> 23:59:59, then 00:00:00 with wrap=1 for 1 cycle only.
// 3. load 00:01:00, dir=0, run
//    -> 00:00:59 after 4 cycles; 00:00:00 after 240 cycles total with done=1.
//    Hold 20 more cycles -> counter and done stay, no tick.
// 4. load 99:75:80 -> 23:59:59 clamped.
//    load asserted on the same cycle as the prescaler terminal count -> load wins, no tick.
// 5. run=1 2 cycles, run=0 10 cycles, run=1 2 cycles -> single step after 4 run-cycles total.
//    Assert rst mid-second -> all outputs 0 asynchronously.
// 6. done=1 then dir=1 -> done clears; 00:00:01 after 4 cycles.

Source files
------------

// File: rtl/hms_clock_counter_if.sv
// Control/preset inputs and time/display outputs of the h:m:s counter core.
// master drives controls (board/bench side), slave is the counter itself.
interface hms_clock_counter_if;
    logic        run;
    logic        dir;
    logic        load;
    logic [7:0]  load_h;
    logic [7:0]  load_m;
    logic [7:0]  load_s;
    logic [7:0]  hours;
    logic [7:0]  minutes;
    logic [7:0]  seconds;
    logic [23:0] number;
    logic        tick;
    logic        wrap;
    logic        done;

    modport master (
        output run, dir, load, load_h, load_m, load_s,
        input  hours, minutes, seconds, number, tick, wrap, done
    );

    modport slave (
        input  run, dir, load, load_h, load_m, load_s,
        output hours, minutes, seconds, number, tick, wrap, done
    );
endinterface

// File: rtl/hms_clock_counter.sv
// Hours/minutes/seconds clock core: prescaler to 1 s steps, up/down counting,
// pause, clamped preset, sticky countdown-done flag and BCD display word.
module hms_clock_counter #(
    parameter int TICK_DIV = 100_000_000,
    parameter int HOUR_MAX = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    hms_clock_counter_if.slave   bus
);
    localparam int              TICK_W    = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [7:0]      H_MAX     = 8'(HOUR_MAX);
    localparam logic [7:0]      MS_MAX    = 8'd59;

    function automatic logic [7:0] clamp(input logic [7:0] v, input logic [7:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    // Values never exceed 99, so one tens/ones split covers every field.
    function automatic logic [7:0] to_bcd(input logic [7:0] v);
        logic [7:0] tens;
        logic [7:0] ones;
        tens = v / 8'd10;
        ones = v - (tens * 8'd10);
        return {tens[3:0], ones[3:0]};
    endfunction

    logic [TICK_W-1:0] presc_r, presc_s;
    logic [7:0]        h_r, h_s;
    logic [7:0]        m_r, m_s;
    logic [7:0]        s_r, s_s;
    logic              tick_r, tick_s;
    logic              wrap_r, wrap_s;
    logic              done_r, done_s;
    logic              presc_en_s;

    // Next-state: load beats any step, otherwise prescaler and time update.
    always_comb begin
        presc_s = presc_r;
        h_s     = h_r;
        m_s     = m_r;
        s_s     = s_r;
        tick_s  = 1'b0;
        wrap_s  = 1'b0;
        done_s  = bus.dir ? 1'b0 : done_r;
        // A finished countdown freezes the prescaler until up-count or load.
        presc_en_s = bus.run && !(!bus.dir && done_r);

        if (bus.load) begin
            presc_s = '0;
            h_s     = clamp(bus.load_h, H_MAX);
            m_s     = clamp(bus.load_m, MS_MAX);
            s_s     = clamp(bus.load_s, MS_MAX);
            done_s  = 1'b0;
        end else if (presc_en_s && (presc_r == TICK_LAST)) begin
            presc_s = '0;
            tick_s  = 1'b1;
            if (bus.dir) begin
                if (s_r == MS_MAX) begin
                    s_s = 8'd0;
                    if (m_r == MS_MAX) begin
                        m_s = 8'd0;
                        if (h_r == H_MAX) begin
                            h_s    = 8'd0;
                            wrap_s = 1'b1;
                        end else begin
                            h_s = h_r + 8'd1;
                        end
                    end else begin
                        m_s = m_r + 8'd1;
                    end
                end else begin
                    s_s = s_r + 8'd1;
                end
            end else begin
                if (s_r == 8'd0) begin
                    s_s = MS_MAX;
                    if (m_r == 8'd0) begin
                        m_s = MS_MAX;
                        h_s = (h_r == 8'd0) ? H_MAX : (h_r - 8'd1);
                    end else begin
                        m_s = m_r - 8'd1;
                    end
                end else begin
                    s_s = s_r - 8'd1;
                end
                done_s = (h_s == 8'd0) && (m_s == 8'd0) && (s_s == 8'd0);
            end
        end else if (presc_en_s) begin
            presc_s = presc_r + TICK_W'(1);
        end else begin
            presc_s = presc_r;
        end
    end

    // State and registered pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r <= '0;
            h_r     <= 8'd0;
            m_r     <= 8'd0;
            s_r     <= 8'd0;
            tick_r  <= 1'b0;
            wrap_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            presc_r <= presc_s;
            h_r     <= h_s;
            m_r     <= m_s;
            s_r     <= s_s;
            tick_r  <= tick_s;
            wrap_r  <= wrap_s;
            done_r  <= done_s;
        end
    end

    assign bus.hours   = h_r;
    assign bus.minutes = m_r;
    assign bus.seconds = s_r;
    assign bus.number  = {to_bcd(h_r), to_bcd(m_r), to_bcd(s_r)};
    assign bus.tick    = tick_r;
    assign bus.wrap    = wrap_r;
    assign bus.done    = done_r;
endmodule
